dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory between two requesters.
- Port A is the MIPS core load/store port. Port B is a secondary master (DMA or debug loader).
- Sits between the core's dmem_addr/dmem_write_data/dmem_write interface and the data memory.
- Port A has fixed priority, with a starvation guard for port B. The arbiter also generates the core stall and routes 1-cycle-latency read data back to the port that issued the read.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave view belongs to the arbiter; the master view to the requesters and memory model.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_write;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              cpu_stall;
    logic              mem_en;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       conflict_cnt;

    modport slave (
        input  a_req, a_write, a_addr, a_wdata,
        input  b_req, b_write, b_addr, b_wdata,
        input  mem_rdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output cpu_stall, mem_en, mem_write, mem_addr, mem_wdata, conflict_cnt
    );

    modport master (
        output a_req, a_write, a_addr, a_wdata,
        output b_req, b_write, b_addr, b_wdata,
        output mem_rdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  cpu_stall, mem_en, mem_write, mem_addr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (port A, priority) and a
// secondary master (port B) with a starvation guard and 1-cycle read return routing.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt;
    logic [15:0]       conflict_cnt;
    logic              vld_p1;
    logic              owner_b_p1;

    logic              b_starved;
    logic              a_gnt_p0;
    logic              b_gnt_p0;
    logic              mem_write_p0;
    logic [ADDR_W-1:0] mem_addr_p0;
    logic [DATA_W-1:0] mem_wdata_p0;

    function automatic logic [3:0] sat_inc_wait(input logic [3:0] v);
        return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 4'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: combinational grant and memory mux from requests and pre-update wait_cnt
    assign b_starved = (wait_cnt == MAX_WAIT_C);
    assign a_gnt_p0  = ~reset & bus.a_req & ~(bus.b_req & b_starved);
    assign b_gnt_p0  = ~reset & bus.b_req & (~bus.a_req | b_starved);

    always_comb begin
        mem_write_p0 = 1'b0;
        mem_addr_p0  = '0;
        mem_wdata_p0 = '0;
        if (a_gnt_p0) begin
            mem_write_p0 = bus.a_write;
            mem_addr_p0  = bus.a_addr;
            mem_wdata_p0 = bus.a_wdata;
        end else if (b_gnt_p0) begin
            mem_write_p0 = bus.b_write;
            mem_addr_p0  = bus.b_addr;
            mem_wdata_p0 = bus.b_wdata;
        end
    end

    assign bus.a_gnt     = a_gnt_p0;
    assign bus.b_gnt     = b_gnt_p0;
    assign bus.cpu_stall = ~reset & bus.a_req & ~a_gnt_p0;
    assign bus.mem_en    = a_gnt_p0 | b_gnt_p0;
    assign bus.mem_write = mem_write_p0;
    assign bus.mem_addr  = mem_addr_p0;
    assign bus.mem_wdata = mem_wdata_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt     <= 4'd0;
            conflict_cnt <= 16'd0;
            vld_p1       <= 1'b0;
            owner_b_p1   <= 1'b0;
        end else begin
            wait_cnt     <= (bus.b_req & ~b_gnt_p0) ? sat_inc_wait(wait_cnt) : 4'd0;
            if (bus.a_req & bus.b_req)
                conflict_cnt <= sat_inc16(conflict_cnt);
            vld_p1       <= (a_gnt_p0 | b_gnt_p0) & ~mem_write_p0;
            owner_b_p1   <= b_gnt_p0;
        end
    end

    // Stage p1: read data returns from memory to whichever port issued the read
    assign bus.a_rvalid     = vld_p1 & ~owner_b_p1;
    assign bus.b_rvalid     = vld_p1 & owner_b_p1;
    assign bus.a_rdata      = (vld_p1 & ~owner_b_p1) ? bus.mem_rdata : '0;
    assign bus.b_rdata      = (vld_p1 & owner_b_p1) ? bus.mem_rdata : '0;
    assign bus.conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-port accesses, contention rotation,
// pipelined reads, asynchronous reset and starvation-counter clearing.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_req = 1'b0; bus.a_write = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_write = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    bit bwin;
    bit prevb;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        idle();

        // Reset state: requests ignored, everything quiet
        bus.a_req = 1'b1;
        step();
        @(negedge clk);
        check("rst_a_gnt", bus.a_gnt, 0);
        check("rst_b_gnt", bus.b_gnt, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_a_rvalid", bus.a_rvalid, 0);
        check("rst_b_rvalid", bus.b_rvalid, 0);
        check("rst_conflict", bus.conflict_cnt, 0);
        step();
        reset = 1'b0;
        idle();
        step();

        // A-only store
        bus.a_req = 1'b1; bus.a_write = 1'b1; bus.a_addr = 32'd84; bus.a_wdata = 32'd7;
        @(negedge clk);
        check("t1_a_gnt", bus.a_gnt, 1);
        check("t1_b_gnt", bus.b_gnt, 0);
        check("t1_mem_en", bus.mem_en, 1);
        check("t1_mem_write", bus.mem_write, 1);
        check("t1_mem_addr", bus.mem_addr, 84);
        check("t1_mem_wdata", bus.mem_wdata, 7);
        check("t1_stall", bus.cpu_stall, 0);
        step();
        idle();
        @(negedge clk);
        check("t1_no_a_rvalid", bus.a_rvalid, 0);
        check("t1_no_b_rvalid", bus.b_rvalid, 0);
        check("t1_idle_mem_en", bus.mem_en, 0);
        check("t1_idle_addr", bus.mem_addr, 0);
        step();

        // B-only load
        bus.b_req = 1'b1; bus.b_write = 1'b0; bus.b_addr = 32'd80;
        @(negedge clk);
        check("t2_b_gnt", bus.b_gnt, 1);
        check("t2_mem_write", bus.mem_write, 0);
        check("t2_mem_addr", bus.mem_addr, 80);
        step();
        idle();
        bus.mem_rdata = 32'h1234;
        @(negedge clk);
        check("t2_b_rvalid", bus.b_rvalid, 1);
        check("t2_b_rdata", bus.b_rdata, 32'h1234);
        check("t2_a_rvalid", bus.a_rvalid, 0);
        check("t2_a_rdata", bus.a_rdata, 0);
        step();
        idle();

        // Continuous contention: B wins every fifth cycle
        bus.a_req = 1'b1; bus.a_write = 1'b0; bus.a_addr = 32'h100;
        bus.b_req = 1'b1; bus.b_write = 1'b0; bus.b_addr = 32'h200;
        prevb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_rdata = 32'hA000 + i;
            @(negedge clk);
            bwin = (i % 5 == 4);
            check("t3_a_gnt", bus.a_gnt, !bwin);
            check("t3_b_gnt", bus.b_gnt, bwin);
            check("t3_stall", bus.cpu_stall, bwin);
            check("t3_addr", bus.mem_addr, bwin ? 32'h200 : 32'h100);
            if (i > 0) begin
                check("t3_a_rvalid", bus.a_rvalid, !prevb);
                check("t3_b_rvalid", bus.b_rvalid, prevb);
                check("t3_rdata", prevb ? bus.b_rdata : bus.a_rdata, 32'hA000 + i);
            end
            prevb = bwin;
            step();
        end
        idle();
        @(negedge clk);
        check("t3_conflict10", bus.conflict_cnt, 10);
        check("t3_last_b_rvalid", bus.b_rvalid, 1);
        step();

        // Back-to-back A loads with no bubbles
        for (int k = 0; k < 4; k++) begin
            bus.a_req = (k < 3);
            bus.a_write = 1'b0;
            bus.a_addr = 32'(4 * k);
            bus.mem_rdata = (k > 0) ? 32'hC0DE_0000 + k : 32'h0;
            @(negedge clk);
            if (k < 3) begin
                check("t4_a_gnt", bus.a_gnt, 1);
                check("t4_addr", bus.mem_addr, 4 * k);
            end
            if (k > 0) begin
                check("t4_a_rvalid", bus.a_rvalid, 1);
                check("t4_a_rdata", bus.a_rdata, 32'hC0DE_0000 + k);
            end
            step();
        end
        idle();

        // Asynchronous reset after an A load grant drops the read
        bus.a_req = 1'b1; bus.a_write = 1'b0; bus.a_addr = 32'h40;
        @(negedge clk);
        check("t5_a_gnt", bus.a_gnt, 1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_rst_a_gnt", bus.a_gnt, 0);
        check("t5_rst_mem_en", bus.mem_en, 0);
        check("t5_rst_stall", bus.cpu_stall, 0);
        check("t5_rst_conflict", bus.conflict_cnt, 0);
        step();
        bus.mem_rdata = 32'hDEAD;
        @(negedge clk);
        check("t5_a_rvalid", bus.a_rvalid, 0);
        check("t5_a_rdata", bus.a_rdata, 0);
        check("t5_mem_addr", bus.mem_addr, 0);
        step();
        reset = 1'b0;
        bus.mem_rdata = 32'h0;
        @(negedge clk);
        check("t5_post_a_gnt", bus.a_gnt, 1);
        check("t5_post_addr", bus.mem_addr, 32'h40);
        step();
        idle();
        bus.mem_rdata = 32'h5555;
        @(negedge clk);
        check("t5_post_rvalid", bus.a_rvalid, 1);
        check("t5_post_rdata", bus.a_rdata, 32'h5555);
        step();
        idle();

        // B denied 3 cycles, drops, then needs 4 fresh denials
        bus.a_req = 1'b1; bus.a_write = 1'b1; bus.a_addr = 32'h10;
        bus.b_req = 1'b1; bus.b_write = 1'b1; bus.b_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_pre_a_gnt", bus.a_gnt, 1);
            check("t6_pre_b_gnt", bus.b_gnt, 0);
            step();
        end
        bus.b_req = 1'b0;
        @(negedge clk);
        check("t6_drop_a_gnt", bus.a_gnt, 1);
        step();
        bus.b_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_a_gnt", bus.a_gnt, i < 4);
            check("t6_b_gnt", bus.b_gnt, i == 4);
            check("t6_no_rvalid", bus.a_rvalid | bus.b_rvalid, 0);
            step();
        end
        idle();
        @(negedge clk);
        check("t6_conflict8", bus.conflict_cnt, 8);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
